// File: rtl/gemm_c_writeback.sv
// Purpose : buffers whole GeMM result blocks and drains them as narrow beats to C memory.
// Latency : a block pushed into an empty FIFO raises mem_req_o the next cycle, then one beat per granted cycle.
// Backpressure: mem_gnt_i low holds the presented beat; the FIFO absorbs FifoDepth blocks, then drops and flags overflow.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              new run: clears overflow_o and any pending completion
//   blk_we_i/addr/wdata  full result block from the accelerator (element e at [e*OutDataWidth +: OutDataWidth])
//   acc_done_i           accelerator finished; completion is reported once all beats are accepted
//   mem_req_o/gnt_i      beat handshake toward C memory (req & gnt = transfer)
//   mem_addr_o/wdata_o   beat address (head_addr*BPB + beat) and beat data
//   fifo_level_o         occupied block entries (a partially drained head still counts)
//   overflow_o, busy_o, done_o  sticky drop flag, activity, one-cycle completion pulse
module gemm_c_writeback #(
    parameter int OutDataWidth = 32,
    parameter int AddrWidth    = 16,
    parameter int meshRow      = 2,
    parameter int meshCol      = 2,
    parameter int BeatElems    = 2,
    parameter int FifoDepth    = 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      start_i,
    input  logic                                      blk_we_i,
    input  logic [AddrWidth-1:0]                      blk_addr_i,
    input  logic [meshRow*meshCol*OutDataWidth-1:0]   blk_wdata_i,
    input  logic                                      acc_done_i,
    output logic                                      mem_req_o,
    input  logic                                      mem_gnt_i,
    output logic [AddrWidth-1:0]                      mem_addr_o,
    output logic [BeatElems*OutDataWidth-1:0]         mem_wdata_o,
    output logic [$clog2(FifoDepth):0]                fifo_level_o,
    output logic                                      overflow_o,
    output logic                                      busy_o,
    output logic                                      done_o
);

    localparam int NumElems = meshRow * meshCol;
    localparam int BlkW     = NumElems * OutDataWidth;
    localparam int BeatW    = BeatElems * OutDataWidth;
    localparam int BPB      = NumElems / BeatElems;
    localparam int PtrW     = $clog2(FifoDepth);
    localparam int LvlW     = PtrW + 1;
    localparam int BIdxW    = (BPB > 1) ? $clog2(BPB) : 1;

    localparam logic [AddrWidth-1:0] BpbA     = AddrWidth'(BPB);
    localparam logic [BIdxW-1:0]     LastBeat = BIdxW'(BPB - 1);
    localparam logic [LvlW-1:0]      FullLvl  = LvlW'(FifoDepth);

    // Block storage carries no reset: contents are only visible while level_q says they are valid.
    logic [AddrWidth-1:0] addr_mem_q [FifoDepth];
    logic [BlkW-1:0]      data_mem_q [FifoDepth];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic [BIdxW-1:0] beat_idx_q, beat_idx_d;
    logic             overflow_q, overflow_d;
    logic             pending_q, pending_d;

    logic                 req;
    logic                 full;
    logic                 xfer;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 done_fire;
    logic [AddrWidth-1:0] head_addr;
    logic [BlkW-1:0]      head_data;
    logic [AddrWidth-1:0] beat_addr;
    logic [BeatW-1:0]     beat_data;

    // Request comes purely from registered occupancy, so blk_we_i never reaches mem_req_o combinationally.
    assign req  = (level_q != '0);
    assign full = (level_q == FullLvl);
    assign xfer = req & mem_gnt_i;
    assign pop  = xfer & (beat_idx_q == LastBeat);
    // A full FIFO still accepts a block in the cycle its head retires, since the slot frees at the same edge.
    assign push = blk_we_i & (~full | pop);
    assign drop = blk_we_i & full & ~pop;

    // No transfer can occur while empty, so empty-and-pending is the complete completion condition.
    assign done_fire = pending_q & ~req;

    assign head_addr = addr_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign beat_addr = head_addr * BpbA + AddrWidth'(beat_idx_q);
    assign beat_data = head_data[beat_idx_q*BeatW +: BeatW];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        beat_idx_d = beat_idx_q;
        overflow_d = overflow_q;
        pending_d  = pending_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase

        if (xfer) begin
            beat_idx_d = (beat_idx_q == LastBeat) ? '0 : beat_idx_q + BIdxW'(1);
        end

        if (start_i) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end

        // start_i wins over acc_done_i; a done pulse while already pending is absorbed.
        if (start_i) begin
            pending_d = 1'b0;
        end else if (done_fire) begin
            pending_d = 1'b0;
        end else if (acc_done_i) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            beat_idx_q <= '0;
            overflow_q <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            beat_idx_q <= beat_idx_d;
            overflow_q <= overflow_d;
            pending_q  <= pending_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= blk_addr_i;
            data_mem_q[wr_ptr_q] <= blk_wdata_i;
        end
    end

    // Address/data are zeroed when idle so stale storage never shows on the port (including right after reset).
    assign mem_req_o    = req;
    assign mem_addr_o   = req ? beat_addr : '0;
    assign mem_wdata_o  = req ? beat_data : '0;
    assign fifo_level_o = level_q;
    assign overflow_o   = overflow_q;
    assign busy_o       = req | pending_q;
    assign done_o       = done_fire;

endmodule

// File: tb/tb_gemm_c_writeback.sv
module tb_gemm_c_writeback;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         start_i;
    logic         blk_we_i;
    logic [15:0]  blk_addr_i;
    logic [127:0] blk_wdata_i;
    logic         acc_done_i;
    logic         mem_req_o;
    logic         mem_gnt_i;
    logic [15:0]  mem_addr_o;
    logic [63:0]  mem_wdata_o;
    logic [2:0]   fifo_level_o;
    logic         overflow_o;
    logic         busy_o;
    logic         done_o;

    gemm_c_writeback #(
        .OutDataWidth(32), .AddrWidth(16), .meshRow(2), .meshCol(2),
        .BeatElems(2), .FifoDepth(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .blk_we_i(blk_we_i), .blk_addr_i(blk_addr_i), .blk_wdata_i(blk_wdata_i),
        .acc_done_i(acc_done_i), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .fifo_level_o(fifo_level_o), .overflow_o(overflow_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [15:0] a;
        logic [63:0] d;
    } beat_t;

    typedef struct {
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  xa0;
        logic [15:0]  xa1;
        logic [63:0]  xd0;
        logic [63:0]  xd1;
    } vec_t;

    beat_t sb_q[$];
    beat_t exp_b;
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one block and, if it should be accepted, queue its two expected beats.
    task automatic set_blk(input logic [15:0] a, input logic [127:0] d, input bit accept);
        logic [15:0] a0;
        a0 = {a[14:0], 1'b0};
        blk_we_i    = 1'b1;
        blk_addr_i  = a;
        blk_wdata_i = d;
        if (accept) begin
            sb_q.push_back('{a: a0,         d: d[63:0]});
            sb_q.push_back('{a: a0 | 16'h1, d: d[127:64]});
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || mem_req_o) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", 64'(n < budget), 64'(1));
        chk("drain_level", 64'(fifo_level_o), 64'(0));
    endtask

    // Scoreboard: every transfer must match the next queued beat.
    always @(negedge clk_i) begin
        if (rst_ni && mem_req_o && mem_gnt_i) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got addr %0h, want no transfer", mem_addr_o);
            end else begin
                exp_b = sb_q.pop_front();
                chk("beat_addr", 64'(mem_addr_o), 64'(exp_b.a));
                chk("beat_data", mem_wdata_o, exp_b.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [5];
        int   xfers;
        int   maxlvl;
        int   dcount;
        int   dat;
        int   first_empty;

        vecs[0] = '{16'h0003, 128'h00000004_00000003_00000002_00000001,
                    16'h0006, 16'h0007, 64'h00000002_00000001, 64'h00000004_00000003};
        vecs[1] = '{16'h0000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                    16'h0000, 16'h0001, 64'hBBBBBBBB_AAAAAAAA, 64'hDDDDDDDD_CCCCCCCC};
        vecs[2] = '{16'h8000, 128'h44444444_33333333_22222222_11111111,
                    16'h0000, 16'h0001, 64'h22222222_11111111, 64'h44444444_33333333};
        vecs[3] = '{16'hFFFF, 128'hFFFFFFFF_00000000_12345678_9ABCDEF0,
                    16'hFFFE, 16'hFFFF, 64'h12345678_9ABCDEF0, 64'hFFFFFFFF_00000000};
        vecs[4] = '{16'h1234, 128'hCAFEF00D_DEADBEEF_0BADC0DE_FEEDFACE,
                    16'h2468, 16'h2469, 64'h0BADC0DE_FEEDFACE, 64'hCAFEF00D_DEADBEEF};

        rst_ni = 1'b0; start_i = 1'b0; blk_we_i = 1'b0; blk_addr_i = '0;
        blk_wdata_i = '0; acc_done_i = 1'b0; mem_gnt_i = 1'b0;
        #2;
        chk("rst_req", 64'(mem_req_o), 64'(0));
        chk("rst_level", 64'(fifo_level_o), 64'(0));
        chk("rst_ovf", 64'(overflow_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_addr", 64'(mem_addr_o), 64'(0));
        tick(); tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_req", 64'(mem_req_o), 64'(0));
        @(posedge clk_i); #1;

        // Single blocks, gnt tied high.
        mem_gnt_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            blk_we_i    = 1'b1;
            blk_addr_i  = vecs[i].addr;
            blk_wdata_i = vecs[i].wdata;
            sb_q.push_back('{a: vecs[i].xa0, d: vecs[i].xd0});
            sb_q.push_back('{a: vecs[i].xa1, d: vecs[i].xd1});
            tick();
            blk_we_i = 1'b0;
            @(negedge clk_i);
            chk("vec_req_latency", 64'(mem_req_o), 64'(1));
            chk("vec_level", 64'(fifo_level_o), 64'(1));
            @(posedge clk_i); #1;
            wait_drain(10);
        end

        // Backpressure: first beat held three cycles.
        mem_gnt_i = 1'b0;
        set_blk(16'd3, 128'h00000004_00000003_00000002_00000001, 1'b1);
        tick();
        blk_we_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("bp_req", 64'(mem_req_o), 64'(1));
            chk("bp_addr", 64'(mem_addr_o), 64'h6);
            chk("bp_data", mem_wdata_o, 64'h00000002_00000001);
            @(posedge clk_i); #1;
        end
        mem_gnt_i = 1'b1;
        wait_drain(10);

        // Back-to-back blocks: eight transfers with no bubble.
        xfers = 0;
        maxlvl = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) set_blk(16'(i), {32'(i*4+4), 32'(i*4+3), 32'(i*4+2), 32'(i*4+1)}, 1'b1);
            else blk_we_i = 1'b0;
            @(negedge clk_i);
            if (i >= 1 && i <= 8) chk("b2b_no_bubble", 64'(mem_req_o), 64'(1));
            if (mem_req_o) xfers++;
            if (int'(fifo_level_o) > maxlvl) maxlvl = int'(fifo_level_o);
            @(posedge clk_i); #1;
        end
        chk("b2b_xfers", 64'(xfers), 64'(8));
        chk("b2b_maxlvl", 64'(maxlvl), 64'(3));
        wait_drain(10);

        // Overflow: fifth block dropped while gnt is low.
        mem_gnt_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_blk(16'(k), {32'(16'h100*k+3), 32'(16'h100*k+2), 32'(16'h100*k+1), 32'(16'h100*k)}, k < 4);
            tick();
            blk_we_i = 1'b0;
            @(negedge clk_i);
            chk("ovf_level", 64'(fifo_level_o), 64'((k < 4) ? k + 1 : 4));
            chk("ovf_flag", 64'(overflow_o), 64'(k == 4));
            @(posedge clk_i); #1;
        end
        mem_gnt_i = 1'b1;
        wait_drain(30);
        chk("ovf_sticky", 64'(overflow_o), 64'(1));
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        @(negedge clk_i);
        chk("ovf_cleared_by_start", 64'(overflow_o), 64'(0));
        @(posedge clk_i); #1;

        // Full FIFO: push lands in the same cycle the head retires.
        mem_gnt_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_blk(16'(10 + k), {32'(k+40), 32'(k+30), 32'(k+20), 32'(k+10)}, 1'b1);
            tick();
        end
        blk_we_i = 1'b0;
        @(negedge clk_i);
        chk("full_level", 64'(fifo_level_o), 64'(4));
        @(posedge clk_i); #1;
        mem_gnt_i = 1'b1;
        tick();
        set_blk(16'd14, 128'h0000000E_0000000D_0000000C_0000000B, 1'b1);
        @(negedge clk_i);
        chk("full_pre_level", 64'(fifo_level_o), 64'(4));
        @(posedge clk_i); #1;
        blk_we_i = 1'b0;
        @(negedge clk_i);
        chk("full_pushpop_level", 64'(fifo_level_o), 64'(4));
        chk("full_pushpop_ovf", 64'(overflow_o), 64'(0));
        @(posedge clk_i); #1;
        wait_drain(30);

        // Done with an empty FIFO comes the cycle after acc_done_i.
        acc_done_i = 1'b1;
        @(negedge clk_i);
        chk("done_empty_early", 64'(done_o), 64'(0));
        @(posedge clk_i); #1;
        acc_done_i = 1'b0;
        @(negedge clk_i);
        chk("done_empty_pulse", 64'(done_o), 64'(1));
        chk("done_empty_busy", 64'(busy_o), 64'(1));
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("done_empty_once", 64'(done_o), 64'(0));
        chk("done_empty_idle", 64'(busy_o), 64'(0));
        @(posedge clk_i); #1;

        // start_i beats a same-cycle acc_done_i.
        acc_done_i = 1'b1;
        start_i = 1'b1;
        tick();
        acc_done_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        chk("start_prio_done", 64'(done_o), 64'(0));
        chk("start_prio_busy", 64'(busy_o), 64'(0));
        @(posedge clk_i); #1;

        // Done waits for the final beat of two queued blocks.
        mem_gnt_i = 1'b0;
        set_blk(16'd20, 128'h00000054_00000053_00000052_00000051, 1'b1);
        tick();
        set_blk(16'd21, 128'h00000064_00000063_00000062_00000061, 1'b1);
        acc_done_i = 1'b1;
        tick();
        blk_we_i = 1'b0;
        acc_done_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("done_held_low", 64'(done_o), 64'(0));
            chk("done_busy", 64'(busy_o), 64'(1));
            @(posedge clk_i); #1;
        end
        mem_gnt_i = 1'b1;
        dcount = 0;
        dat = -1;
        first_empty = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (fifo_level_o == 0 && first_empty < 0) first_empty = i;
            if (done_o) begin
                dcount++;
                dat = i;
            end
            @(posedge clk_i); #1;
        end
        chk("done_count", 64'(dcount), 64'(1));
        chk("done_cycle", 64'(dat), 64'(4));
        chk("done_first_empty", 64'(first_empty), 64'(4));
        chk("done_sb_empty", 64'(sb_q.size()), 64'(0));

        // Reset while beat 1 of a block is presented.
        mem_gnt_i = 1'b1;
        set_blk(16'd5, 128'h00000004_00000003_00000002_00000001, 1'b1);
        tick();
        blk_we_i = 1'b0;
        tick();
        chk("mid_beat1_addr", 64'(mem_addr_o), 64'hB);
        rst_ni = 1'b0;
        #1;
        chk("mrst_req", 64'(mem_req_o), 64'(0));
        chk("mrst_level", 64'(fifo_level_o), 64'(0));
        chk("mrst_busy", 64'(busy_o), 64'(0));
        chk("mrst_addr", 64'(mem_addr_o), 64'(0));
        chk("mrst_data", mem_wdata_o, 64'(0));
        sb_q.delete();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("mrst_no_req", 64'(mem_req_o), 64'(0));
            @(posedge clk_i); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
